adam_gpio: RTL and testbench
============================

# adam_gpio

APB-controlled general-purpose I/O peripheral for the ADAM SoC periphery. It exposes GPIO_WIDTH pins through per-pin I/O interfaces, with output data, direction, output type and a 2-bit alternate-function select per pin. It drives a level interrupt from enabled input pins and implements the ADAM pause handshake so the system can quiesce it between bus transfers.

## Interface
- Parameters come from the standard ADAM config map:
- ADDR_WIDTH, 32: APB address width; register stride is ADDR_WIDTH/8 bytes.
- DATA_WIDTH, 32: APB data width.
- GPIO_WIDTH, 32: number of pins; GPIO_WIDTH ≤ DATA_WIDTH, multiple of 8.
- Ports:
- seq.clk  in  1  clock.
- seq.rst  in  1  reset; one clock; reset is asynchronous and active-high.
- pause.req  in  1  pause request.
- pause.ack  out  1  pause acknowledge.
- slv  APB slave  ADDR_WIDTH/DATA_WIDTH  register access: paddr, psel, penable, pwrite, pwdata, pstrb in; prdata, pready, pslverr out.
- irq  out  1  interrupt, level, active-high.
- io[i].i  in  1  pin input.
- io[i].o  out  1  pin output value (ODR bit i).
- io[i].mode  out  1  pin direction (MODER bit i, 1 = output).
- io[i].otype  out  1  output type (OTYPER bit i, 1 = open-drain).
- func[i]  out  2  alternate-function select for pin i.

## Operation
- Registers, offsets in bytes for 32-bit APB:
- 0x00 IDR: read-only synchronised pin inputs. A write returns PSLVERR=1 and changes nothing.
- 0x04 ODR, 0x08 MODER, 0x0C OTYPER, 0x18 IER: read/write, GPIO_WIDTH bits.
- 0x10 FSR0, 0x14 FSR1: read/write. Bit k of the concatenation {FSR1,FSR0} drives func[k/2][k%2]. Pin i uses bits 2i and 2i+1.
- Writes honour pstrb per byte; unstrobed bytes are preserved. Valid writes return PSLVERR=0.
- Reads of all seven registers return PSLVERR=0, with data zero-extended to DATA_WIDTH.
- Offsets ≥ 0x1C return PSLVERR=1 and read data 0.
- irq = OR over i of (IER[i] & IDR[i]), registered.
- Pause:
  - When pause.req rises, any in-flight APB access completes first, then pause.ack is asserted.
  - While ack=1, pready is held 0 (accesses stall), and registers and outputs hold their values.
  - After req falls, ack falls on the next clock.
- Reset values:
  - All registers 0, so o, mode, otype, func and irq are 0.
  - pause.ack = 1, i.e. the block comes out of reset paused until req is low.
  - pready = 0, pslverr = 0, prdata = 0.

## Timing
- IDR samples io[i].i every clock; a pin change is visible in an IDR read within 2 cycles.
- irq follows IER/IDR changes within 1 cycle of the register update.
- APB accesses have zero wait states when not paused: pready=1 in the ACCESS phase.
- A write takes effect on the pins on the clock edge ending the ACCESS phase.
- The read value reflects all prior completed writes (back-to-back write→read is coherent).
- Simultaneous pause.req and psel: an access already in ACCESS phase completes; an access still in SETUP phase stalls until unpaused.
- Reset asserted mid-transfer aborts it; all state returns to reset values immediately.

## Structure
- Shared package holds:
  - register offset constants (IDR..IER);
  - GPIO_T (logic [GPIO_WIDTH-1:0]), ADDR_T, DATA_T, STRB_T.
- A sub-module adam_gpio_regs is the natural split: APB decode, strobe merge and response generation. The top holds the input synchroniser, FSR fan-out, irq logic and pause FSM.
- Pause FSM states:
  - RUN → DRAIN when req=1 and an access is in flight.
  - RUN or DRAIN → PAUSED when req=1 and the bus is idle.
  - PAUSED → RUN on req=0.
  - Reset enters PAUSED.

## Test plan
- Reset, drop pause.req, write ODR=0xA5A5A5A5 strb=0xF → io[i].o matches, ODR reads 0xA5A5A5A5, OKAY.
- Write MODER=0xFFFFFFFF with strb=0x2 → MODER=0x0000FF00; other bytes preserved.
- Write FSR0=0x0000000E, FSR1=0xC0000000 → func[1]=2'b11, func[0]=2'b10, func[31]=2'b11, others 0.
- Drive pins=0x00000010, write IER=0x00000010 → irq=1; pins=0 → IDR reads 0 and irq=0.
- Write IDR → PSLVERR=1 and IDR unaffected; read offset 0x1C → PSLVERR=1.
- Assert pause.req during random traffic → ack only after the access completes, no access completes while ack=1, and register contents are unchanged after release.

Source files
------------

// File: rtl/adam_gpio_pkg.sv
// ---------------------------------------------------------------------------
// adam_gpio_pkg
// Shared definitions for the ADAM GPIO peripheral.
//   - Configuration widths (address, data, pin count) from the ADAM config map.
//   - Register offset constants for the APB register file.
//   - Common vector types used by the register block, the top and the bus
//     interface.
//   - strobeMerge(): byte-lane merge helper used by every writable register.
// ---------------------------------------------------------------------------
package adam_gpio_pkg;

  // Configuration. GPIO_WIDTH must not exceed DATA_WIDTH and must be a
  // multiple of 8 so every pin register fits in one bus word.
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int GPIO_WIDTH = 32;
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int REG_STRIDE = ADDR_WIDTH / 8;

  typedef logic [GPIO_WIDTH-1:0] GPIO_T;
  typedef logic [ADDR_WIDTH-1:0] ADDR_T;
  typedef logic [DATA_WIDTH-1:0] DATA_T;
  typedef logic [STRB_WIDTH-1:0] STRB_T;

  // Register map, one register per bus word.
  localparam ADDR_T OFFSET_IDR    = ADDR_T'(0 * REG_STRIDE);
  localparam ADDR_T OFFSET_ODR    = ADDR_T'(1 * REG_STRIDE);
  localparam ADDR_T OFFSET_MODER  = ADDR_T'(2 * REG_STRIDE);
  localparam ADDR_T OFFSET_OTYPER = ADDR_T'(3 * REG_STRIDE);
  localparam ADDR_T OFFSET_FSR0   = ADDR_T'(4 * REG_STRIDE);
  localparam ADDR_T OFFSET_FSR1   = ADDR_T'(5 * REG_STRIDE);
  localparam ADDR_T OFFSET_IER    = ADDR_T'(6 * REG_STRIDE);

  // Replaces only the byte lanes whose strobe is set; other lanes keep the
  // old register contents.
  function automatic DATA_T strobeMerge(DATA_T oldVal, DATA_T newVal, STRB_T strb);
    DATA_T merged;
    merged = oldVal;
    for (int b = 0; b < STRB_WIDTH; b++) begin
      if (strb[b]) begin
        merged[b*8 +: 8] = newVal[b*8 +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/adam_gpio_if.sv
// ---------------------------------------------------------------------------
// adam_gpio_if
// APB bus bundle used to reach the GPIO register file.
//   master modport: drives paddr, psel, penable, pwrite, pwdata, pstrb;
//                   receives prdata, pready, pslverr.
//   slave modport:  the mirror image, used by adam_gpio and adam_gpio_regs.
// ---------------------------------------------------------------------------
interface adam_gpio_if;
  import adam_gpio_pkg::*;

  ADDR_T paddr;
  logic  psel;
  logic  penable;
  logic  pwrite;
  DATA_T pwdata;
  STRB_T pstrb;
  DATA_T prdata;
  logic  pready;
  logic  pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata, pstrb,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/adam_gpio_regs.sv
// ---------------------------------------------------------------------------
// adam_gpio_regs
// APB register file of the GPIO block: address decode, byte-strobe merge and
// response generation (zero wait states unless stalled).
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   apb        APB slave port
//   stall_i    holds pready low so no access can complete (pause)
//   idr_i      synchronised pin inputs, readable at the IDR offset
//   odr_o      output data register
//   moder_o    direction register (1 = output)
//   otyper_o   output type register (1 = open-drain)
//   fsr0_o     function select, low half
//   fsr1_o     function select, high half
//   ier_o      interrupt enable register
// ---------------------------------------------------------------------------
module adam_gpio_regs
  import adam_gpio_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  adam_gpio_if.slave apb,
  input  logic  stall_i,
  input  GPIO_T idr_i,
  output GPIO_T odr_o,
  output GPIO_T moder_o,
  output GPIO_T otyper_o,
  output GPIO_T fsr0_o,
  output GPIO_T fsr1_o,
  output GPIO_T ier_o
);

  GPIO_T odr_q, odr_d;
  GPIO_T moder_q, moder_d;
  GPIO_T otyper_q, otyper_d;
  GPIO_T fsr0_q, fsr0_d;
  GPIO_T fsr1_q, fsr1_d;
  GPIO_T ier_q, ier_d;

  logic  accessPhase;
  logic  accept;
  logic  addrValid;
  logic  addrWritable;
  ADDR_T alignedAddr;
  DATA_T readData;

  // An access completes in the ACCESS phase unless the pause logic stalls it.
  assign accessPhase = apb.psel & apb.penable;
  assign accept      = accessPhase & ~stall_i;

  // Byte offsets inside a register word are ignored for decoding.
  assign alignedAddr = apb.paddr & ~ADDR_T'(REG_STRIDE - 1);

  // Address decode and read multiplexer. Unmapped offsets read as zero and
  // flag an error; IDR is the only mapped register that rejects writes.
  always_comb begin
    readData     = '0;
    addrValid    = 1'b1;
    addrWritable = 1'b1;
    case (alignedAddr)
      OFFSET_IDR: begin
        readData     = DATA_T'(idr_i);
        addrWritable = 1'b0;
      end
      OFFSET_ODR:    readData = DATA_T'(odr_q);
      OFFSET_MODER:  readData = DATA_T'(moder_q);
      OFFSET_OTYPER: readData = DATA_T'(otyper_q);
      OFFSET_FSR0:   readData = DATA_T'(fsr0_q);
      OFFSET_FSR1:   readData = DATA_T'(fsr1_q);
      OFFSET_IER:    readData = DATA_T'(ier_q);
      default: begin
        addrValid    = 1'b0;
        addrWritable = 1'b0;
      end
    endcase
  end

  // Next-state for the writable registers: only an accepted, error-free write
  // touches the addressed register, and only in its strobed byte lanes.
  always_comb begin
    odr_d    = odr_q;
    moder_d  = moder_q;
    otyper_d = otyper_q;
    fsr0_d   = fsr0_q;
    fsr1_d   = fsr1_q;
    ier_d    = ier_q;
    if (accept && apb.pwrite && addrWritable) begin
      case (alignedAddr)
        OFFSET_ODR:    odr_d    = GPIO_T'(strobeMerge(DATA_T'(odr_q),    apb.pwdata, apb.pstrb));
        OFFSET_MODER:  moder_d  = GPIO_T'(strobeMerge(DATA_T'(moder_q),  apb.pwdata, apb.pstrb));
        OFFSET_OTYPER: otyper_d = GPIO_T'(strobeMerge(DATA_T'(otyper_q), apb.pwdata, apb.pstrb));
        OFFSET_FSR0:   fsr0_d   = GPIO_T'(strobeMerge(DATA_T'(fsr0_q),   apb.pwdata, apb.pstrb));
        OFFSET_FSR1:   fsr1_d   = GPIO_T'(strobeMerge(DATA_T'(fsr1_q),   apb.pwdata, apb.pstrb));
        OFFSET_IER:    ier_d    = GPIO_T'(strobeMerge(DATA_T'(ier_q),    apb.pwdata, apb.pstrb));
        default: ;
      endcase
    end
  end

  // Register state; everything clears immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      odr_q    <= '0;
      moder_q  <= '0;
      otyper_q <= '0;
      fsr0_q   <= '0;
      fsr1_q   <= '0;
      ier_q    <= '0;
    end else begin
      odr_q    <= odr_d;
      moder_q  <= moder_d;
      otyper_q <= otyper_d;
      fsr0_q   <= fsr0_d;
      fsr1_q   <= fsr1_d;
      ier_q    <= ier_d;
    end
  end

  // Responses are only driven while the access is being accepted, so a
  // stalled or idle bus sees pready, pslverr and prdata all low.
  assign apb.pready  = accept;
  assign apb.pslverr = accept & (~addrValid | (apb.pwrite & ~addrWritable));
  assign apb.prdata  = (accept && !apb.pwrite) ? readData : '0;

  assign odr_o    = odr_q;
  assign moder_o  = moder_q;
  assign otyper_o = otyper_q;
  assign fsr0_o   = fsr0_q;
  assign fsr1_o   = fsr1_q;
  assign ier_o    = ier_q;

endmodule

// File: rtl/adam_gpio.sv
// ---------------------------------------------------------------------------
// adam_gpio
// APB-controlled GPIO peripheral for the ADAM SoC periphery.
// Ports:
//   clk, rst       clock and asynchronous active-high reset
//   pause_req_i    pause request from the system
//   pause_ack_o    pause acknowledge; high while the block is quiesced
//   apb            APB slave port (register access)
//   irq_o          level interrupt: any enabled pin reading high
//   pin_i          raw pin inputs
//   pin_o          pin output values (ODR)
//   pin_mode_o     pin direction (MODER, 1 = output)
//   pin_otype_o    pin output type (OTYPER, 1 = open-drain)
//   func_o         2-bit alternate-function select per pin
// ---------------------------------------------------------------------------
module adam_gpio
  import adam_gpio_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  pause_req_i,
  output logic  pause_ack_o,
  adam_gpio_if.slave apb,
  output logic  irq_o,
  input  GPIO_T pin_i,
  output GPIO_T pin_o,
  output GPIO_T pin_mode_o,
  output GPIO_T pin_otype_o,
  output logic [GPIO_WIDTH-1:0][1:0] func_o
);

  localparam logic [1:0] STATE_RUN    = 2'd0;
  localparam logic [1:0] STATE_DRAIN  = 2'd1;
  localparam logic [1:0] STATE_PAUSED = 2'd2;

  logic [1:0] pauseState_q, pauseState_d;
  logic       busAccess;
  logic       paused;

  GPIO_T pinSync_q;
  GPIO_T idr_q;
  logic  irq_q;

  GPIO_T odr;
  GPIO_T moder;
  GPIO_T otyper;
  GPIO_T fsr0;
  GPIO_T fsr1;
  GPIO_T ier;
  logic [2*GPIO_WIDTH-1:0] fsrCat;

  assign busAccess = apb.psel & apb.penable;
  assign paused    = (pauseState_q == STATE_PAUSED);

  // Pause sequencing. An access already in its ACCESS phase is allowed to
  // finish (DRAIN); a transfer that is only in SETUP is caught by the pause
  // and stalls in ACCESS until the request is withdrawn.
  always_comb begin
    pauseState_d = pauseState_q;
    case (pauseState_q)
      STATE_RUN: begin
        if (pause_req_i) begin
          pauseState_d = busAccess ? STATE_DRAIN : STATE_PAUSED;
        end
      end
      STATE_DRAIN: begin
        if (!pause_req_i) begin
          pauseState_d = STATE_RUN;
        end else if (!busAccess) begin
          pauseState_d = STATE_PAUSED;
        end
      end
      STATE_PAUSED: begin
        if (!pause_req_i) begin
          pauseState_d = STATE_RUN;
        end
      end
      default: pauseState_d = STATE_PAUSED;
    endcase
  end

  // The block leaves reset paused and only starts once the request is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pauseState_q <= STATE_PAUSED;
    end else begin
      pauseState_q <= pauseState_d;
    end
  end

  // Two-flop pin synchroniser feeding IDR, followed by the registered
  // interrupt. All of it is frozen while paused so visible state holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pinSync_q <= '0;
      idr_q     <= '0;
      irq_q     <= 1'b0;
    end else if (!paused) begin
      pinSync_q <= pin_i;
      idr_q     <= pinSync_q;
      irq_q     <= |(ier & idr_q);
    end
  end

  adam_gpio_regs u_regs (
    .clk      (clk),
    .rst      (rst),
    .apb      (apb),
    .stall_i  (paused),
    .idr_i    (idr_q),
    .odr_o    (odr),
    .moder_o  (moder),
    .otyper_o (otyper),
    .fsr0_o   (fsr0),
    .fsr1_o   (fsr1),
    .ier_o    (ier)
  );

  // {FSR1,FSR0} is one 2*GPIO_WIDTH bit field; pin i takes bits 2i+1:2i.
  assign fsrCat = {fsr1, fsr0};

  always_comb begin
    for (int i = 0; i < GPIO_WIDTH; i++) begin
      func_o[i] = fsrCat[2*i +: 2];
    end
  end

  assign pin_o       = odr;
  assign pin_mode_o  = moder;
  assign pin_otype_o = otyper;
  assign irq_o       = irq_q;
  assign pause_ack_o = paused;

endmodule

// File: tb/tb_adam_gpio.sv
// ---------------------------------------------------------------------------
// tb_adam_gpio
// Self-checking bench for adam_gpio. APB transfers push their expected
// response onto a scoreboard queue; a monitor pops and compares whenever the
// DUT completes an access. Pin-level outputs are checked against a small
// register model kept by the bench.
// ---------------------------------------------------------------------------
module tb_adam_gpio;

  localparam int WAIT_LIMIT = 200;

  typedef struct {
    string       tag;
    logic        isRead;
    logic [31:0] data;
    logic        err;
  } sbEntry_t;

  logic        clk;
  logic        rst;
  logic        pauseReq;
  logic        pauseAck;
  logic        irq;
  logic [31:0] pins;
  logic [31:0] pinOut;
  logic [31:0] pinMode;
  logic [31:0] pinOtype;
  logic [31:0][1:0] func;

  int checkCount = 0;
  int errorCount = 0;

  sbEntry_t sbQueue[$];
  sbEntry_t monEntry;

  logic [31:0] mIdr, mOdr, mModer, mOtyper, mFsr0, mFsr1, mIer;
  logic [31:0] addrTable [9];
  bit          trafficDone;

  adam_gpio_if apbIf ();

  adam_gpio dut (
    .clk         (clk),
    .rst         (rst),
    .pause_req_i (pauseReq),
    .pause_ack_o (pauseAck),
    .apb         (apbIf),
    .irq_o       (irq),
    .pin_i       (pins),
    .pin_o       (pinOut),
    .pin_mode_o  (pinMode),
    .pin_otype_o (pinOtype),
    .func_o      (func)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute time limit so the run can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] mergeModel(logic [31:0] oldVal, logic [31:0] newVal, logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (oldVal & ~mask) | (newVal & mask);
  endfunction

  function automatic logic modelValid(logic [31:0] addr);
    return addr < 32'h1C;
  endfunction

  function automatic logic [31:0] modelRead(logic [31:0] addr);
    case (addr)
      32'h00:  return mIdr;
      32'h04:  return mOdr;
      32'h08:  return mModer;
      32'h0C:  return mOtyper;
      32'h10:  return mFsr0;
      32'h14:  return mFsr1;
      32'h18:  return mIer;
      default: return 32'h0;
    endcase
  endfunction

  function automatic void modelWrite(logic [31:0] addr, logic [31:0] data, logic [3:0] strb);
    case (addr)
      32'h04:  mOdr    = mergeModel(mOdr, data, strb);
      32'h08:  mModer  = mergeModel(mModer, data, strb);
      32'h0C:  mOtyper = mergeModel(mOtyper, data, strb);
      32'h10:  mFsr0   = mergeModel(mFsr0, data, strb);
      32'h14:  mFsr1   = mergeModel(mFsr1, data, strb);
      32'h18:  mIer    = mergeModel(mIer, data, strb);
      default: ;
    endcase
  endfunction

  // One APB transfer; the expected response goes on the scoreboard before
  // the bus is driven.
  task automatic applyStimulus(input string tag, input logic wr, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] strb);
    sbEntry_t e;
    int       waitCnt;
    bit       done;
    e.tag    = tag;
    e.isRead = !wr;
    e.err    = !modelValid(addr) || (wr && addr == 32'h00);
    e.data   = wr ? 32'h0 : modelRead(addr);
    if (wr && !e.err) modelWrite(addr, data, strb);
    sbQueue.push_back(e);
    @(posedge clk); #1;
    apbIf.psel    = 1'b1;
    apbIf.penable = 1'b0;
    apbIf.pwrite  = wr;
    apbIf.paddr   = addr;
    apbIf.pwdata  = data;
    apbIf.pstrb   = strb;
    @(posedge clk); #1;
    apbIf.penable = 1'b1;
    waitCnt = 0;
    done    = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (apbIf.pready) begin
        done = 1'b1;
      end else begin
        waitCnt++;
        if (waitCnt > WAIT_LIMIT) begin
          checkOutput({tag, "_timeout"}, 64'd1, 64'd0);
          void'(sbQueue.pop_back());
          done = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    apbIf.psel    = 1'b0;
    apbIf.penable = 1'b0;
    apbIf.pwrite  = 1'b0;
  endtask

  // Scoreboard monitor: compares each completed access and guards against
  // any completion while the block acknowledges a pause.
  always @(negedge clk) begin
    if (!rst && apbIf.psel && apbIf.penable) begin
      if (pauseAck) checkOutput("stall_while_paused", 64'(apbIf.pready), 64'd0);
      if (apbIf.pready) begin
        if (sbQueue.size() == 0) begin
          checkOutput("sb_unexpected", 64'd1, 64'd0);
        end else begin
          monEntry = sbQueue.pop_front();
          checkOutput({monEntry.tag, "_err"}, 64'(apbIf.pslverr), 64'(monEntry.err));
          if (monEntry.isRead) checkOutput({monEntry.tag, "_rdata"}, 64'(apbIf.prdata), 64'(monEntry.data));
        end
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0]      snapO, snapMode, snapOtype;
    logic [31:0][1:0] snapFunc;
    logic             snapIrq;
    int               ackWait;

    addrTable = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h40};
    mIdr = 0; mOdr = 0; mModer = 0; mOtyper = 0; mFsr0 = 0; mFsr1 = 0; mIer = 0;
    trafficDone   = 1'b0;
    rst           = 1'b1;
    pauseReq      = 1'b1;
    pins          = 32'h0;
    apbIf.psel    = 1'b0;
    apbIf.penable = 1'b0;
    apbIf.pwrite  = 1'b0;
    apbIf.paddr   = 32'h0;
    apbIf.pwdata  = 32'h0;
    apbIf.pstrb   = 4'h0;

    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("rst_ack", 64'(pauseAck), 64'd1);
    checkOutput("rst_pready", 64'(apbIf.pready), 64'd0);
    checkOutput("rst_pslverr", 64'(apbIf.pslverr), 64'd0);
    checkOutput("rst_prdata", 64'(apbIf.prdata), 64'd0);
    checkOutput("rst_pins", {pinMode, pinOut}, 64'd0);
    checkOutput("rst_otype", 64'(pinOtype), 64'd0);
    checkOutput("rst_func", 64'(func), 64'd0);
    checkOutput("rst_irq", 64'(irq), 64'd0);

    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ack_held_req", 64'(pauseAck), 64'd1);
    @(posedge clk); #1;
    pauseReq = 1'b0;
    @(negedge clk);
    checkOutput("ack_before_edge", 64'(pauseAck), 64'd1);
    @(negedge clk);
    checkOutput("ack_released", 64'(pauseAck), 64'd0);

    // ODR full write and read-back.
    applyStimulus("odr_wr", 1'b1, 32'h04, 32'hA5A5A5A5, 4'hF);
    checkOutput("odr_pins", 64'(pinOut), 64'h00000000A5A5A5A5);
    applyStimulus("odr_rd", 1'b0, 32'h04, 32'h0, 4'h0);

    // Partial-strobe writes.
    applyStimulus("moder_wr", 1'b1, 32'h08, 32'hFFFFFFFF, 4'h2);
    checkOutput("moder_pins", 64'(pinMode), 64'h000000000000FF00);
    applyStimulus("moder_rd", 1'b0, 32'h08, 32'h0, 4'h0);
    applyStimulus("odr_part", 1'b1, 32'h04, 32'h12345678, 4'h9);
    checkOutput("odr_part_pins", 64'(pinOut), 64'h0000000012A5A578);

    // Function select fan-out.
    applyStimulus("fsr0_wr", 1'b1, 32'h10, 32'h0000000E, 4'hF);
    applyStimulus("fsr1_wr", 1'b1, 32'h14, 32'hC0000000, 4'hF);
    checkOutput("func0", 64'(func[0]), 64'd2);
    checkOutput("func1", 64'(func[1]), 64'd3);
    checkOutput("func31", 64'(func[31]), 64'd3);
    checkOutput("func_all", 64'(func), 64'hC00000000000000E);
    applyStimulus("fsr1_rd", 1'b0, 32'h14, 32'h0, 4'h0);

    // Output type.
    applyStimulus("otyper_wr", 1'b1, 32'h0C, 32'h0F0F00F0, 4'hF);
    checkOutput("otype_pins", 64'(pinOtype), 64'h000000000F0F00F0);

    // Input path and interrupt.
    pins = 32'h00000010; mIdr = pins;
    waitCycles(3);
    applyStimulus("ier_wr", 1'b1, 32'h18, 32'h00000010, 4'hF);
    waitCycles(1);
    checkOutput("irq_set", 64'(irq), 64'd1);
    applyStimulus("idr_rd_hi", 1'b0, 32'h00, 32'h0, 4'h0);
    pins = 32'h0; mIdr = pins;
    waitCycles(4);
    checkOutput("irq_clr", 64'(irq), 64'd0);
    applyStimulus("idr_rd_lo", 1'b0, 32'h00, 32'h0, 4'h0);

    // Error responses.
    applyStimulus("idr_wr", 1'b1, 32'h00, 32'hFFFFFFFF, 4'hF);
    applyStimulus("idr_rd_after", 1'b0, 32'h00, 32'h0, 4'h0);
    applyStimulus("bad_rd", 1'b0, 32'h1C, 32'h0, 4'h0);
    applyStimulus("bad_wr", 1'b1, 32'h1C, 32'h12345678, 4'hF);
    applyStimulus("ier_rd", 1'b0, 32'h18, 32'h0, 4'h0);

    // Random traffic with pauses interleaved.
    pins = 32'h5A5A0F0F; mIdr = pins;
    waitCycles(4);
    fork
      begin
        for (int n = 0; n < 120; n++) begin
          applyStimulus("rand", 1'($urandom_range(0, 1)), addrTable[$urandom_range(0, 8)],
                        $urandom, 4'($urandom_range(0, 15)));
        end
        trafficDone = 1'b1;
      end
      begin
        while (!trafficDone) begin
          repeat ($urandom_range(3, 15)) @(posedge clk);
          #1;
          pauseReq = 1'b1;
          ackWait  = 0;
          while (!pauseAck && ackWait < 50) begin
            @(negedge clk);
            ackWait++;
          end
          checkOutput("pause_ack_rise", 64'(pauseAck), 64'd1);
          snapO     = pinOut;
          snapMode  = pinMode;
          snapOtype = pinOtype;
          snapFunc  = func;
          snapIrq   = irq;
          repeat ($urandom_range(2, 8)) @(negedge clk);
          checkOutput("pause_hold_o", 64'(pinOut), 64'(snapO));
          checkOutput("pause_hold_mode", 64'(pinMode), 64'(snapMode));
          checkOutput("pause_hold_otype", 64'(pinOtype), 64'(snapOtype));
          checkOutput("pause_hold_func", 64'(func), 64'(snapFunc));
          checkOutput("pause_hold_irq", 64'(irq), 64'(snapIrq));
          @(posedge clk); #1;
          pauseReq = 1'b0;
          @(negedge clk);
          checkOutput("pause_ack_hold", 64'(pauseAck), 64'd1);
          @(negedge clk);
          checkOutput("pause_ack_fall", 64'(pauseAck), 64'd0);
        end
      end
    join

    // Final state against the model.
    checkOutput("final_odr", 64'(pinOut), 64'(mOdr));
    checkOutput("final_moder", 64'(pinMode), 64'(mModer));
    checkOutput("final_otyper", 64'(pinOtype), 64'(mOtyper));
    checkOutput("final_func", 64'(func), {mFsr1, mFsr0});
    for (int k = 0; k < 7; k++) begin
      applyStimulus("final_rd", 1'b0, addrTable[k], 32'h0, 4'h0);
    end
    checkOutput("final_irq", 64'(irq), 64'(|(mIer & mIdr)));
    checkOutput("sb_drain", 64'(sbQueue.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
